uart_tx_top: RTL and testbench
==============================

Name: uart_tx_top

Overview:
- 16550-style UART transmit subsystem: CPU-visible register file, 16-entry transmit FIFO, baud generator and serial transmitter with RTS/CTS flow control.
- Sits between a simple byte-wide register bus (wr_en/rd_en/address) and the serial TX pin.
- tx_done flags each completed frame.

Parameters:
- FIFO_DEPTH, 16, transmit FIFO entries. Pointers are log2(depth)+1 bits, with the extra bit used for full/empty.
- OVERSAMPLE, 16, baud ticks per serial bit.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  8  write data.
- wr_en  in  1  register write strobe, one write per cycle while high.
- rd_en  in  1  register read strobe.
- address  in  3  register select.
- n_CTS  in  1  clear-to-send, active low; 0 permits frame start.
- data_o  out  8  registered read data.
- serial_data_out  out  1  TX line; idle high.
- n_RTS  out  1  request-to-send, active low; equals ~MCR[1].
- tx_done  out  1  one-cycle pulse at end of each frame's last stop bit.

Behaviour:
- Register map, with DLAB = LCR[7]:
  - addr 0: write THR (push to FIFO) when DLAB=0; DLL when DLAB=1.
  - addr 1: IER when DLAB=0 (stored only, no interrupt logic); DLH when DLAB=1.
  - addr 3: LCR.
  - addr 4: MCR.
  - addr 5: LSR, read-only. bit5 = FIFO empty; bit6 = FIFO empty and transmitter idle; other bits 0.
  - Writes to unused addresses are ignored. Reads of unmapped addresses return 0. Reading addr 0 returns DLL when DLAB=1, else 0.
- Reads: when rd_en=1, data_o is updated next cycle with the selected register; otherwise data_o holds.
- LCR fields:
  - [1:0] word length: 00=5, 01=6, 10=7, 11=8 bits.
  - [2] stop bits: 0=1, 1=2.
  - [3] parity enable.
  - [4] even parity when 1, odd when 0.
  - [7] DLAB.
  - LCR is sampled at frame start; writes mid-frame affect the next frame only.
- Reset values:
  - All registers 0 (LCR=00, DLL=DLH=0, MCR=0, IER=0). FIFO empty.
  - serial_data_out=1, n_RTS=1, tx_done=0, data_o=0.
  - Reset mid-frame aborts the frame immediately, forcing the line high.
- Baud generator:
  - divisor = {DLH,DLL}; a 16-bit counter emits a 1-cycle tick every divisor clocks.
  - divisor=0 means no ticks and the transmitter stalls.
  - Writing DLL/DLH reloads the counter.
- Transmitter FSM: IDLE -> START -> DATA -> PARITY (skipped when disabled) -> STOP -> IDLE.
  - Each bit lasts OVERSAMPLE ticks, i.e. 16*divisor clocks.
  - IDLE: when FIFO non-empty and n_CTS=0, pop one byte and go to START.
  - n_CTS is checked only in IDLE; a frame in progress always completes.
  - DATA bits are sent LSB first, count = word length; upper bits of the byte are ignored.
  - Parity bit: odd = ~^data, even = ^data, computed over the transmitted bits only.
  - STOP drives 1 for 1 or 2 bits. tx_done pulses in the cycle STOP ends.
  - Back-to-back frames: the next START begins the cycle after STOP ends if the FIFO is non-empty and n_CTS=0.
- FIFO:
  - A push when full is dropped.
  - Pop and push in the same cycle are both honoured.
  - Pointers wrap modulo depth.
- n_RTS is a combinational reflection of ~MCR[1] (registered MCR).

Decomposition:
- Package uart_pkg holds:
  - Register address constants (ADDR_THR_DLL=0, ADDR_IER_DLH=1, ADDR_LCR=3, ADDR_MCR=4, ADDR_LSR=5).
  - LCR bit positions.
  - FSM state enum.
  - FIFO_DEPTH and OVERSAMPLE defaults.
- One sub-module is natural: uart_tx_fifo (synchronous FIFO with full/empty flags). The baud generator and FSM stay in the top.

Test Plan:
- Reset: rst=1 -> serial_data_out=1, n_RTS=1, tx_done=0, data_o=0, LSR read = 0x60.
- Config and single frame:
  - Stimulus: write LCR=80, DLL=46, DLH=01, LCR=0F, MCR=02, THR=55, with n_CTS=0.
  - Response: n_RTS=0. Bit period = 16*326 = 5216 clocks.
  - Line sequence: 0,1,0,1,0,1,0,1,0, parity 1, stop 1,1.
  - tx_done pulses once after 12 bit periods.
- Back-to-back frames:
  - Stimulus: config as above, then write THR=55, then THR=57 (this second write reaches the FIFO because DLAB=0 after LCR=0F), then write addr1=AB.
  - Response: two frames; the second carries 0x57 with parity 0. IER=AB and DLH stays 01 (verify by readback with DLAB=1).
- Flow control: n_CTS=1 with FIFO loaded -> line stays 1. Release n_CTS -> frame starts within one baud tick.
- Format variants:
  - LCR=00 (5N1): byte 0x1F sends 5 ones and 1 stop bit, 7 bits total.
  - LCR=1B (8E1): 0x57 gets parity bit 1.
- FIFO full and reset mid-frame:
  - 17 THR writes with n_CTS=1 -> only 16 frames are sent.
  - Asserting rst mid-frame -> line high immediately, FIFO empty.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: register map, LCR/MCR fields, FSM states, sizing defaults.
// Pure declarations; no logic, no latency, no flow control.
package uart_pkg;

    localparam int FIFO_DEPTH_DEF = 16;
    localparam int OVERSAMPLE_DEF = 16;

    localparam logic [2:0] ADDR_THR_DLL = 3'd0;
    localparam logic [2:0] ADDR_IER_DLH = 3'd1;
    localparam logic [2:0] ADDR_LCR     = 3'd3;
    localparam logic [2:0] ADDR_MCR     = 3'd4;
    localparam logic [2:0] ADDR_LSR     = 3'd5;

    localparam int LCR_WLS_LSB = 0;
    localparam int LCR_STB     = 2;
    localparam int LCR_PEN     = 3;
    localparam int LCR_EPS     = 4;
    localparam int LCR_DLAB    = 7;
    localparam int MCR_RTS     = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Index of the last data bit: 5..8 data bits map to 4..7.
    function automatic logic [2:0] word_last(input logic [1:0] wls);
        return 3'd4 + {1'b0, wls};
    endfunction

    function automatic logic [7:0] word_mask(input logic [1:0] wls);
        return 8'hFF >> (3'd3 - {1'b0, wls});
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO with full/empty flags; head entry is readable combinationally.
// Pushes while full are dropped; a simultaneous pop and push both take effect.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push_vld,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop_rdy,
    output logic [WIDTH-1:0] o_pop_dat,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    // The extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_push    = i_push_vld && !o_full;
    assign w_pop     = i_pop_rdy && !o_empty;
    assign o_pop_dat = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/uart_tx_top.sv
// 16550-style UART transmitter: register file, TX FIFO, baud generator and framing FSM.
// Reads return next cycle; frames start on a baud tick with data queued and n_CTS low.
module uart_tx_top
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic [2:0] address,
    input  logic       n_CTS,
    output logic [7:0] data_o,
    output logic       serial_data_out,
    output logic       n_RTS,
    output logic       tx_done
);

    localparam int OSW = $clog2(OVERSAMPLE);
    localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0] OS_ONE  = 1;

    logic [7:0]     r_lcr, r_dll, r_dlh, r_ier, r_mcr, r_data_o;
    logic [15:0]    r_baud_cnt;
    logic           r_tick;
    tx_state_t      r_state;
    logic [OSW-1:0] r_os_cnt;
    logic [2:0]     r_bit_cnt;
    logic [7:0]     r_shift;
    logic [2:0]     r_frm_last;
    logic           r_frm_stb, r_frm_pen, r_par, r_serial, r_tx_done;

    logic           w_dlab, w_thr_wr, w_div_wr;
    logic [15:0]    w_divisor;
    logic           w_fifo_empty, w_fifo_full;
    logic [7:0]     w_fifo_dat, w_masked, w_rd_dat;
    logic           w_par, w_bit_end, w_stop_end, w_start;

    assign w_dlab    = r_lcr[LCR_DLAB];
    assign w_divisor = {r_dlh, r_dll};
    assign w_thr_wr  = wr_en && (address == ADDR_THR_DLL) && !w_dlab && !w_fifo_full;
    assign w_div_wr  = wr_en && w_dlab && ((address == ADDR_THR_DLL) || (address == ADDR_IER_DLH));

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push_vld (w_thr_wr),
        .i_push_dat (data_in),
        .i_pop_rdy  (w_start),
        .o_pop_dat  (w_fifo_dat),
        .o_empty    (w_fifo_empty),
        .o_full     (w_fifo_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lcr <= '0;
            r_dll <= '0;
            r_dlh <= '0;
            r_ier <= '0;
            r_mcr <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_THR_DLL: if (w_dlab) r_dll <= data_in;
                ADDR_IER_DLH: if (w_dlab) r_dlh <= data_in; else r_ier <= data_in;
                ADDR_LCR:     r_lcr <= data_in;
                ADDR_MCR:     r_mcr <= data_in;
                default:      ;
            endcase
        end
    end

    always_comb begin
        w_rd_dat = 8'h00;
        case (address)
            ADDR_THR_DLL: w_rd_dat = w_dlab ? r_dll : 8'h00;
            ADDR_IER_DLH: w_rd_dat = w_dlab ? r_dlh : r_ier;
            ADDR_LCR:     w_rd_dat = r_lcr;
            ADDR_MCR:     w_rd_dat = r_mcr;
            ADDR_LSR:     w_rd_dat = {1'b0, w_fifo_empty && (r_state == ST_IDLE), w_fifo_empty, 5'b0};
            default:      w_rd_dat = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_o <= '0;
        end else if (rd_en) begin
            r_data_o <= w_rd_dat;
        end
    end

    // Divisor writes restart the count so the new rate takes effect cleanly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baud_cnt <= '0;
            r_tick     <= 1'b0;
        end else if (w_div_wr || (w_divisor == 16'd0)) begin
            r_baud_cnt <= '0;
            r_tick     <= 1'b0;
        end else if (r_baud_cnt == w_divisor - 16'd1) begin
            r_baud_cnt <= '0;
            r_tick     <= 1'b1;
        end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
            r_tick     <= 1'b0;
        end
    end

    assign w_masked   = w_fifo_dat & word_mask(r_lcr[LCR_WLS_LSB +: 2]);
    assign w_par      = r_lcr[LCR_EPS] ? (^w_masked) : (~^w_masked);
    assign w_bit_end  = r_tick && (r_os_cnt == OS_LAST);
    assign w_stop_end = (r_state == ST_STOP) && w_bit_end && (r_bit_cnt == {2'b00, r_frm_stb});
    assign w_start    = !w_fifo_empty && !n_CTS && (((r_state == ST_IDLE) && r_tick) || w_stop_end);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_os_cnt   <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_frm_last <= '0;
            r_frm_stb  <= 1'b0;
            r_frm_pen  <= 1'b0;
            r_par      <= 1'b0;
            r_serial   <= 1'b1;
            r_tx_done  <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            if (w_start) begin
                // Frame format is latched here so later LCR writes only affect the next frame.
                r_state    <= ST_START;
                r_serial   <= 1'b0;
                r_os_cnt   <= '0;
                r_bit_cnt  <= '0;
                r_shift    <= w_masked;
                r_frm_last <= word_last(r_lcr[LCR_WLS_LSB +: 2]);
                r_frm_stb  <= r_lcr[LCR_STB];
                r_frm_pen  <= r_lcr[LCR_PEN];
                r_par      <= w_par;
                r_tx_done  <= w_stop_end;
            end else if ((r_state != ST_IDLE) && r_tick) begin
                if (r_os_cnt != OS_LAST) begin
                    r_os_cnt <= r_os_cnt + OS_ONE;
                end else begin
                    r_os_cnt <= '0;
                    case (r_state)
                        ST_START: begin
                            r_state  <= ST_DATA;
                            r_serial <= r_shift[0];
                            r_shift  <= r_shift >> 1;
                        end
                        ST_DATA: begin
                            if (r_bit_cnt == r_frm_last) begin
                                r_bit_cnt <= '0;
                                r_state   <= r_frm_pen ? ST_PARITY : ST_STOP;
                                r_serial  <= r_frm_pen ? r_par : 1'b1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                                r_serial  <= r_shift[0];
                                r_shift   <= r_shift >> 1;
                            end
                        end
                        ST_PARITY: begin
                            r_state  <= ST_STOP;
                            r_serial <= 1'b1;
                        end
                        ST_STOP: begin
                            if (r_bit_cnt == {2'b00, r_frm_stb}) begin
                                r_state   <= ST_IDLE;
                                r_tx_done <= 1'b1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                        default: begin
                            r_state  <= ST_IDLE;
                            r_serial <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    assign data_o          = r_data_o;
    assign serial_data_out = r_serial;
    assign tx_done         = r_tx_done;
    assign n_RTS           = ~r_mcr[MCR_RTS];

endmodule

// File: tb/tb_uart_tx_top.sv
// Bench for uart_tx_top: directed register/frame stimulus, queued expectations checked by
// independent read and serial-line monitors.
module tb_uart_tx_top;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       wr_en;
    logic       rd_en;
    logic [2:0] address;
    logic       n_CTS;
    logic [7:0] data_o;
    logic       serial_data_out;
    logic       n_RTS;
    logic       tx_done;

    typedef struct packed { logic [3:0] n; logic [11:0] bits; } frame_t;
    typedef struct packed { logic [2:0] a; logic [7:0] v; } rd_t;

    frame_t exp_q[$];
    rd_t    rd_q[$];
    int     checks     = 0;
    int     errors     = 0;
    int     bit_clks   = 32;
    int     done_cnt   = 0;
    int     frames_exp = 0;
    logic   mon_en     = 1'b0;
    logic   mon_busy   = 1'b0;
    logic   b2b        = 1'b0;
    logic   rd_seen    = 1'b0;

    uart_tx_top dut (
        .clk             (clk),
        .rst             (rst),
        .data_in         (data_in),
        .wr_en           (wr_en),
        .rd_en           (rd_en),
        .address         (address),
        .n_CTS           (n_CTS),
        .data_o          (data_o),
        .serial_data_out (serial_data_out),
        .n_RTS           (n_RTS),
        .tx_done         (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        address = a;
        data_in = d;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] v);
        rd_t r;
        @(negedge clk);
        address = a;
        rd_en   = 1'b1;
        r.a = a;
        r.v = v;
        rd_q.push_back(r);
        @(negedge clk);
        rd_en   = 1'b0;
    endtask

    task automatic push_frame(input logic [3:0] n, input logic [11:0] bits);
        frame_t f;
        f.n    = n;
        f.bits = bits;
        exp_q.push_back(f);
        frames_exp++;
    endtask

    task automatic wait_fall(input int limit, output int n);
        n = 0;
        while (serial_data_out !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic measure_level(input logic lvl, input int limit, output int n);
        n = 0;
        while (serial_data_out === lvl && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", (exp_q.size() != 0 || mon_busy), 0);
    endtask

    always @(posedge clk) rd_seen <= rd_en;

    always @(negedge clk) begin : rd_mon
        rd_t r;
        if (rd_seen) begin
            if (rd_q.size() == 0) begin
                check("read_unexpected", 1, 0);
            end else begin
                r = rd_q.pop_front();
                check($sformatf("read_addr%0d", r.a), data_o, r.v);
            end
        end
    end

    always @(negedge clk) if (tx_done === 1'b1) done_cnt++;

    // Serial monitor: samples each bit mid-period, then expects tx_done exactly at frame end.
    initial begin : ser_mon
        frame_t      e;
        logic [11:0] got;
        int          idx;
        idx = 0;
        forever begin
            if (mon_en && serial_data_out === 1'b0) begin
                mon_busy = 1'b1;
                if (exp_q.size() == 0) begin
                    check("frame_unexpected", 1, 0);
                    repeat (bit_clks * 12) @(negedge clk);
                end else begin
                    e   = exp_q.pop_front();
                    got = '0;
                    repeat (bit_clks / 2) @(negedge clk);
                    for (int i = 0; i < int'(e.n); i++) begin
                        got[i] = serial_data_out;
                        if (i < int'(e.n) - 1) repeat (bit_clks) @(negedge clk);
                    end
                    check($sformatf("frame%0d_bits", idx), {20'h0, got}, {20'h0, e.bits});
                    repeat (bit_clks / 2) @(negedge clk);
                    check($sformatf("frame%0d_tx_done", idx), tx_done, 1);
                    if (b2b && exp_q.size() != 0)
                        check($sformatf("frame%0d_b2b_start", idx), serial_data_out, 0);
                    idx++;
                end
                mon_busy = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int low;
        int base;
        rst     = 1'b1;
        data_in = 8'h00;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        address = 3'd0;
        n_CTS   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_line", serial_data_out, 1);
        check("rst_n_rts", n_RTS, 1);
        check("rst_tx_done", tx_done, 0);
        check("rst_data_o", data_o, 8'h00);
        rst = 1'b0;
        rd(3'd5, 8'h60);
        repeat (3) @(negedge clk);
        check("data_o_hold", data_o, 8'h60);

        // Divisor 0x0146 = 326: register map readback and exact bit period.
        wr(3'd3, 8'h80); wr(3'd0, 8'h46); wr(3'd1, 8'h01); wr(3'd3, 8'h0F); wr(3'd4, 8'h02);
        wr(3'd1, 8'hAB);
        check("n_rts_asserted", n_RTS, 0);
        wr(3'd3, 8'h8F);
        rd(3'd0, 8'h46); rd(3'd1, 8'h01); rd(3'd3, 8'h8F);
        wr(3'd3, 8'h0F);
        rd(3'd1, 8'hAB); rd(3'd0, 8'h00); rd(3'd4, 8'h02); rd(3'd2, 8'h00); rd(3'd6, 8'h00);
        wr(3'd0, 8'h55); wr(3'd0, 8'h57);
        rd(3'd5, 8'h00);
        n_CTS = 1'b0;
        wait_fall(400, n);
        check("slow_start_seen", (n < 400), 1);
        measure_level(1'b0, 6000, n);
        check("slow_start_bit_clks", n, 5216);
        measure_level(1'b1, 6000, n);
        check("slow_data0_clks", n, 5216);
        rst = 1'b1;
        #1;
        check("rst_mid_frame_line", serial_data_out, 1);
        check("rst_mid_frame_n_rts", n_RTS, 1);
        @(negedge clk);
        rst = 1'b0;
        rd(3'd5, 8'h60);

        // Divisor 2 (32 clocks per bit) for the monitored frames.
        n_CTS = 1'b1;
        wr(3'd3, 8'h80); wr(3'd0, 8'h02); wr(3'd1, 8'h00); wr(3'd3, 8'h0F); wr(3'd4, 8'h02);
        bit_clks = 32;
        base     = done_cnt;
        mon_en   = 1'b1;
        b2b      = 1'b1;
        n_CTS    = 1'b0;
        push_frame(4'd12, 12'hEAA);
        push_frame(4'd12, 12'hCAE);
        wr(3'd0, 8'h55); wr(3'd0, 8'h57);
        wait_done(2000);
        b2b = 1'b0;
        rd(3'd5, 8'h60);

        // Flow control with 5N1.
        wr(3'd3, 8'h00);
        n_CTS = 1'b1;
        push_frame(4'd7, 12'h07E);
        wr(3'd0, 8'h1F);
        low = 0;
        repeat (200) begin
            @(negedge clk);
            if (serial_data_out !== 1'b1) low++;
        end
        check("cts_hold_line", low, 0);
        n_CTS = 1'b0;
        wait_fall(10, n);
        check("cts_release_latency", (n <= 3), 1);
        wait_done(1000);

        // 8E1 and 6O2 (upper data bits ignored for parity).
        wr(3'd3, 8'h1B);
        push_frame(4'd11, 12'h6AE);
        wr(3'd0, 8'h57);
        wait_done(1000);
        wr(3'd3, 8'h0D);
        push_frame(4'd10, 12'h386);
        wr(3'd0, 8'h43);
        wait_done(1000);

        // 17 writes into a 16-deep FIFO: the last one is dropped.
        wr(3'd3, 8'h00);
        n_CTS = 1'b1;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) push_frame(4'd7, {5'b0, 1'b1, i[4:0], 1'b0});
            wr(3'd0, 8'(i));
        end
        rd(3'd5, 8'h00);
        b2b   = 1'b1;
        n_CTS = 1'b0;
        wait_done(6000);
        b2b = 1'b0;
        repeat (400) @(negedge clk);
        check("tx_done_count", done_cnt - base, frames_exp);
        rd(3'd5, 8'h60);
        repeat (3) @(negedge clk);
        check("read_queue_empty", rd_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
